// File: rtl/img_proc_engine.sv
// img_proc_engine: single-command image processor (vertical/horizontal mirror,
// grayscale, 3x3 sharpen). Reads a W x H source image through a synchronous
// row/col port and writes every output pixel once in raster order.
module img_proc_engine #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int AW       = 6,
    parameter int CW       = 8,
    parameter int NCH      = 3,
    parameter int GRAY_REP = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       row,
    output logic [AW-1:0]       col,
    input  logic [NCH*CW-1:0]   in_pix,
    output logic [AW-1:0]       out_row,
    output logic [AW-1:0]       out_col,
    output logic                out_we,
    output logic [NCH*CW-1:0]   out_pix
);
    localparam int PW  = NCH * CW;
    localparam int SW  = CW + 5;              // signed sharpen accumulator width
    localparam int GCH = (NCH > 1) ? 1 : 0;   // gray channel when not replicated
    localparam logic [AW-1:0] W_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] H_LAST = AW'(IMG_H - 1);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << CW) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_SAMPLE, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [1:0]          mode_q, m_sel;
    logic [AW-1:0]       r, c, r_n, c_n;
    logic [1:0]          tr, tc, tr_n, tc_n;   // tap offset (0..2) around (r,c)
    logic                load_addr, cur_int, is_last;
    logic [AW-1:0]       base_r, base_c, addr_r, addr_c;
    logic [PW-1:0]       pix_q, result;
    logic signed [SW-1:0] acc [NCH];
    logic [CW-1:0]       gmax, gmin, g;
    logic [CW:0]         gsum;

    // Sharpen uses all nine taps only away from the image border.
    function automatic logic interior(input logic [1:0] m, input logic [AW-1:0] rr,
                                      input logic [AW-1:0] cc);
        return (m == 2'd3) && (rr != '0) && (rr != H_LAST) && (cc != '0) && (cc != W_LAST);
    endfunction

    // Contribution of one sampled channel: 9x for the center, minus each neighbour.
    function automatic logic signed [SW-1:0] tap_term(input logic [CW-1:0] v, input logic ctr);
        logic signed [SW-1:0] e;
        e = $signed({5'b0, v});
        return ctr ? (e <<< 3) + e : -e;
    endfunction

    assign cur_int = interior(mode_q, r, c);
    assign is_last = (r == H_LAST) && (c == W_LAST);

    // Next-state, pixel/tap counter advance and address-load decision.
    always_comb begin
        state_n   = state;
        r_n       = r;
        c_n       = c;
        tr_n      = tr;
        tc_n      = tc;
        load_addr = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_ADDR;
                    r_n       = '0;
                    c_n       = '0;
                    tr_n      = 2'd1;   // (0,0) is always a one-tap pixel
                    tc_n      = 2'd1;
                    load_addr = 1'b1;
                end
            end
            S_ADDR:   state_n = S_SAMPLE;
            S_SAMPLE: begin
                if (cur_int && !(tr == 2'd2 && tc == 2'd2)) begin
                    state_n   = S_ADDR;
                    load_addr = 1'b1;
                    if (tc == 2'd2) begin
                        tc_n = 2'd0;
                        tr_n = tr + 2'd1;
                    end else begin
                        tc_n = tc + 2'd1;
                    end
                end else begin
                    state_n = S_CALC;
                end
            end
            S_CALC:   state_n = S_WRITE;
            S_WRITE: begin
                if (is_last) begin
                    state_n = S_DONE;
                end else begin
                    state_n   = S_ADDR;
                    load_addr = 1'b1;
                    if (c == W_LAST) begin
                        c_n = '0;
                        r_n = r + AW'(1);
                    end else begin
                        c_n = c + AW'(1);
                    end
                    if (interior(mode_q, r_n, c_n)) begin
                        tr_n = 2'd0;
                        tc_n = 2'd0;
                    end else begin
                        tr_n = 2'd1;
                        tc_n = 2'd1;
                    end
                end
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Read address for the tap about to be issued; mode comes straight from the
    // port in the accept cycle because mode_q is not loaded yet.
    always_comb begin
        m_sel  = (state == S_IDLE) ? mode : mode_q;
        base_r = r_n + AW'(tr_n) - AW'(1);
        base_c = c_n + AW'(tc_n) - AW'(1);
        addr_r = (m_sel == 2'd0) ? H_LAST - base_r : base_r;
        addr_c = (m_sel == 2'd1) ? W_LAST - base_c : base_c;
    end

    // Control state, counters, read address and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= 2'd0;
            r      <= '0;
            c      <= '0;
            tr     <= 2'd1;
            tc     <= 2'd1;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b0;
        end else begin
            state <= state_n;
            r     <= r_n;
            c     <= c_n;
            tr    <= tr_n;
            tc    <= tc_n;
            if (state == S_IDLE && start) begin
                mode_q <= mode;
                busy   <= 1'b1;
            end else if (state == S_DONE) begin
                busy   <= 1'b0;
            end
            if (load_addr) begin
                row <= addr_r;
                col <= addr_c;
            end
        end
    end

    // Capture the read data; sharpen accumulates per channel as taps arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
            for (int ch = 0; ch < NCH; ch++) acc[ch] <= '0;
        end else if (state == S_SAMPLE) begin
            pix_q <= in_pix;
            for (int ch = 0; ch < NCH; ch++) begin
                acc[ch] <= ((tr == 2'd0 && tc == 2'd0) ? '0 : acc[ch])
                         + tap_term(in_pix[ch*CW +: CW], (tr == 2'd1 && tc == 2'd1));
            end
        end
    end

    // Result for the current pixel: pass-through, grayscale or clamped sharpen.
    always_comb begin
        result = pix_q;
        gmax   = pix_q[CW-1:0];
        gmin   = pix_q[CW-1:0];
        for (int ch = 1; ch < NCH; ch++) begin
            if (pix_q[ch*CW +: CW] > gmax) gmax = pix_q[ch*CW +: CW];
            if (pix_q[ch*CW +: CW] < gmin) gmin = pix_q[ch*CW +: CW];
        end
        gsum = {1'b0, gmax} + {1'b0, gmin};
        g    = CW'(gsum >> 1);
        if (mode_q == 2'd2) begin
            result = '0;
            if (GRAY_REP != 0) begin
                for (int ch = 0; ch < NCH; ch++) result[ch*CW +: CW] = g;
            end else begin
                result[GCH*CW +: CW] = g;
            end
        end else if (cur_int) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (acc[ch][SW-1])      result[ch*CW +: CW] = '0;
                else if (acc[ch] > MAXV) result[ch*CW +: CW] = '1;
                else                     result[ch*CW +: CW] = acc[ch][CW-1:0];
            end
        end
    end

    // Write port and done pulse; data/address hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_we  <= 1'b0;
            out_row <= '0;
            out_col <= '0;
            out_pix <= '0;
            done    <= 1'b0;
        end else begin
            out_we <= (state == S_CALC);
            done   <= (state == S_WRITE) && is_last;
            if (state == S_CALC) begin
                out_row <= r;
                out_col <= c;
                out_pix <= result;
            end
        end
    end

endmodule

// File: tb/tb_img_proc_engine.sv
// Directed bench for img_proc_engine: three instances (64x64 RGB, 5x4 RGB with
// replicated gray, 5x3 single 4-bit channel) driven one at a time.
module tb_img_proc_engine;
    logic clk = 1'b0;
    logic rst, start;
    logic [1:0] mode;
    int sel;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance A: 64x64, NCH=3, CW=8, GRAY_REP=0
    logic start_a, busy_a, done_a, we_a;
    logic [5:0] row_a, col_a, orow_a, ocol_a;
    logic [23:0] pix_a, opix_a;
    logic [23:0] mem_a [64][64];
    logic [23:0] oa [64][64];
    int wc_a = 0;

    // Instance B: 5x4, NCH=3, CW=8, GRAY_REP=1
    logic start_b, busy_b, done_b, we_b;
    logic [2:0] row_b, col_b, orow_b, ocol_b;
    logic [23:0] pix_b, opix_b;
    logic [23:0] mem_b [8][8];
    logic [23:0] ob [8][8];
    int wc_b = 0;

    // Instance C: 5x3, NCH=1, CW=4
    logic start_c, busy_c, done_c, we_c;
    logic [2:0] row_c, col_c, orow_c, ocol_c;
    logic [3:0] pix_c, opix_c;
    logic [3:0] mem_c [8][8];
    logic [3:0] oc [8][8];
    logic [2:0] seq_r [32];
    logic [2:0] seq_c [32];
    int wc_c = 0;

    logic busy_m, done_m;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    always_comb begin
        busy_m = busy_a;
        done_m = done_a;
        if (sel == 1) begin
            busy_m = busy_b;
            done_m = done_b;
        end else if (sel == 2) begin
            busy_m = busy_c;
            done_m = done_c;
        end
    end

    img_proc_engine u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .busy(busy_a), .done(done_a),
        .row(row_a), .col(col_a), .in_pix(pix_a), .out_row(orow_a), .out_col(ocol_a),
        .out_we(we_a), .out_pix(opix_a));

    img_proc_engine #(.IMG_W(5), .IMG_H(4), .AW(3), .CW(8), .NCH(3), .GRAY_REP(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .busy(busy_b), .done(done_b),
        .row(row_b), .col(col_b), .in_pix(pix_b), .out_row(orow_b), .out_col(ocol_b),
        .out_we(we_b), .out_pix(opix_b));

    img_proc_engine #(.IMG_W(5), .IMG_H(3), .AW(3), .CW(4), .NCH(1), .GRAY_REP(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .busy(busy_c), .done(done_c),
        .row(row_c), .col(col_c), .in_pix(pix_c), .out_row(orow_c), .out_col(ocol_c),
        .out_we(we_c), .out_pix(opix_c));

    // Synchronous source memories: data for {row,col} appears the next cycle.
    always @(posedge clk) begin
        pix_a <= mem_a[row_a][col_a];
        pix_b <= mem_b[row_b][col_b];
        pix_c <= mem_c[row_c][col_c];
    end

    // Output image capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            oa[orow_a][ocol_a] <= opix_a;
            wc_a <= wc_a + 1;
        end
        if (we_b === 1'b1) begin
            ob[orow_b][ocol_b] <= opix_b;
            wc_b <= wc_b + 1;
        end
        if (we_c === 1'b1) begin
            oc[orow_c][ocol_c] <= opix_c;
            seq_r[wc_c % 32] <= orow_c;
            seq_c[wc_c % 32] <= ocol_c;
            wc_c <= wc_c + 1;
        end
    end

    function automatic logic [23:0] pat(input int r, input int c);
        return {8'(r), 8'(c), 8'(r ^ c)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge. Accept edge is cycle 0; cycle k is the period
    // ending at edge k. With poke set, start is pulsed mid-command and again in
    // the done cycle; both must be ignored.
    task automatic run_cmd(input int s, input logic [1:0] m, input bit poke, input int limit,
                           output int dcyc, output int berr);
        dcyc  = -1;
        berr  = 0;
        sel   = s;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (poke && k == 5) begin
                start = 1'b1;
                mode  = 2'd2;
            end
            if (poke && k == 6) start = 1'b0;
            if (busy_m !== 1'b1) berr++;
            if (done_m === 1'b1) begin
                dcyc = k;
                break;
            end
        end
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy_m !== 1'b0) berr++;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] ctr;
        logic [23:0] nb;
        int          r0, c0;
        logic [23:0] e0;
        int          r1, c1;
        logic [23:0] e1;
        int          dc;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [8];
        int dc, be, base, errs;

        // Instance B vectors: (1,1) holds ctr, every other pixel nb.
        tbl[0] = '{2'd3, 24'h646464, 24'h5A5A5A, 1, 1, 24'hB4B4B4, 2, 2, 24'h505050, 177};
        tbl[1] = '{2'd3, 24'hFFFFFF, 24'h000000, 1, 1, 24'hFFFFFF, 0, 0, 24'h000000, 177};
        tbl[2] = '{2'd3, 24'h000000, 24'hFFFFFF, 1, 1, 24'h000000, 1, 0, 24'hFFFFFF, 177};
        tbl[3] = '{2'd3, 24'h0A64C8, 24'h145AB4, 1, 1, 24'h00B4FF, 3, 2, 24'h145AB4, 177};
        tbl[4] = '{2'd2, 24'hC83264, 24'h10FF20, 1, 1, 24'h7D7D7D, 0, 0, 24'h878787, 81};
        tbl[5] = '{2'd0, 24'h112233, 24'h445566, 2, 1, 24'h112233, 0, 0, 24'h445566, 81};
        tbl[6] = '{2'd1, 24'h112233, 24'h445566, 1, 3, 24'h112233, 1, 1, 24'h445566, 81};
        tbl[7] = '{2'd3, 24'h808080, 24'h7F7F7F, 1, 1, 24'h888888, 3, 4, 24'h7F7F7F, 177};

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) mem_a[r][c] = pat(r, c);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                mem_b[r][c] = '0;
                mem_c[r][c] = 4'((r < 3 && c < 5) ? r * 5 + c : 0);
            end

        sel   = 0;
        mode  = 2'd0;
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a", {busy_a, done_a, we_a, row_a, col_a, orow_a, ocol_a, opix_a}, 64'd0);
        check("reset_b", {busy_b, done_b, we_b, row_b, col_b, orow_b, ocol_b, opix_b}, 64'd0);
        check("reset_c", {busy_c, done_c, we_c, row_c, col_c, orow_c, ocol_c, opix_c}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vertical mirror over the full 64x64 image.
        base = wc_a;
        run_cmd(0, 2'd0, 1'b0, 20000, dc, be);
        check("m0_done_cycle", dc, 16385);
        check("m0_busy", be, 0);
        check("m0_writes", wc_a - base, 4096);
        errs = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (oa[r][c] !== pat(63 - r, c)) errs++;
        check("m0_image_errors", errs, 0);

        // Reset in the middle of a sharpen command.
        sel   = 0;
        mode  = 2'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        base = wc_a;
        check("rst_mid_outputs", {busy_a, done_a, we_a, row_a, col_a}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_no_writes", wc_a - base, 0);
        check("rst_mid_idle", {busy_a, done_a}, 64'd0);

        // Grayscale after the abort, single channel placement.
        mem_a[5][7] = 24'hC83264;
        base = wc_a;
        run_cmd(0, 2'd2, 1'b0, 20000, dc, be);
        check("m2_done_cycle", dc, 16385);
        check("m2_busy", be, 0);
        check("m2_writes", wc_a - base, 4096);
        check("m2_px_5_7", oa[5][7], 24'h007D00);
        check("m2_px_0_0", oa[0][0], 24'h000000);
        check("m2_px_63_63", oa[63][63], 24'h001F00);
        check("m2_px_10_3", oa[10][3], 24'h000600);

        // Table of small-image commands on instance B.
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 5; c++) mem_b[r][c] = tbl[i].nb;
            mem_b[1][1] = tbl[i].ctr;
            base = wc_b;
            run_cmd(1, tbl[i].mode, 1'b0, 400, dc, be);
            check($sformatf("vec%0d_done_cycle", i), dc, tbl[i].dc);
            check($sformatf("vec%0d_busy", i), be, 0);
            check($sformatf("vec%0d_writes", i), wc_b - base, 20);
            check($sformatf("vec%0d_px_%0d_%0d", i, tbl[i].r0, tbl[i].c0),
                  ob[tbl[i].r0][tbl[i].c0], tbl[i].e0);
            check($sformatf("vec%0d_px_%0d_%0d", i, tbl[i].r1, tbl[i].c1),
                  ob[tbl[i].r1][tbl[i].c1], tbl[i].e1);
        end

        // Horizontal mirror on 5x3 with start pulses while busy and in the done cycle.
        base = wc_c;
        run_cmd(2, 2'd1, 1'b1, 200, dc, be);
        check("m1_done_cycle", dc, 61);
        check("m1_busy", be, 0);
        check("m1_writes", wc_c - base, 15);
        errs = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (oc[r][c] !== 4'(r * 5 + 4 - c)) errs++;
        check("m1_image_errors", errs, 0);
        check("m1_wr4_pos", {seq_r[(base + 4) % 32], seq_c[(base + 4) % 32]}, {3'd0, 3'd4});
        check("m1_wr5_wrap", {seq_r[(base + 5) % 32], seq_c[(base + 5) % 32]}, {3'd1, 3'd0});

        // Back-to-back start in the first cycle after busy falls.
        base = wc_c;
        run_cmd(2, 2'd0, 1'b0, 200, dc, be);
        check("b2b_done_cycle", dc, 61);
        check("b2b_busy", be, 0);
        check("b2b_writes", wc_c - base, 15);
        check("b2b_px_0_0", oc[0][0], 4'd10);
        check("b2b_px_2_4", oc[2][4], 4'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/img_proc_engine.md
Name: img_proc_engine

Overview:
Parametrised successor of the fixed 64x64 mirror/grayscale/sharpen image processor. It executes one command per `start`: vertical mirror, horizontal mirror, grayscale or 3x3 sharpen. Each command reads a W x H input image through a synchronous row/col read port and writes a separate output image through its own write address. Image size, channel width and channel count are parameters. A `start`/`busy`/`done` handshake replaces the one-shot power-up sequence.

Parameters:
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in pixels (>=3)
AW, 6, row/col address width; must satisfy 2^AW >= max(IMG_W, IMG_H)
CW, 8, bits per colour channel
NCH, 3, channel count; channel NCH-1 in MSBs (R), channel 0 in LSBs (B)
GRAY_REP, 0, 0: gray value in channel 1 only (channel 0 if NCH=1), others 0; 1: gray value replicated into all channels

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  command request, sampled in IDLE only
mode  in  2  0 vertical mirror, 1 horizontal mirror, 2 grayscale, 3 sharpen; sampled with start
busy  out  1  high from start acceptance through the done cycle
done  out  1  one-cycle pulse, command complete
row  out  AW  input image read row
col  out  AW  input image read column
in_pix  in  NCH*CW  input pixel at {row,col}; must be valid the cycle after row/col change
out_row  out  AW  output write row
out_col  out  AW  output write column
out_we  out  1  output write enable, one cycle per pixel
out_pix  out  NCH*CW  output pixel data

Behaviour:
- Reset (async, any state): FSM goes to IDLE; pixel counters 0; all outputs 0. No write occurs after rst rises. A command in flight is abandoned and done is not pulsed.
- States: IDLE, ADDR, SAMPLE, CALC, WRITE, DONE.
- IDLE: start=1 latches mode, sets busy=1 at that edge, pixel (r,c)=(0,0), then goes to ADDR. start while busy is ignored.
- ADDR drives row/col for the current tap. SAMPLE captures in_pix at the next edge.
- Taps per pixel:
  - Modes 0, 1, 2: one tap.
  - Mode 3 interior pixel (0<r<H-1, 0<c<W-1): nine taps, ADDR/SAMPLE alternating, row-major order (r-1,c-1) ... (r+1,c+1).
  - Mode 3 border pixel: one tap at (r,c).
- Tap addresses:
  - Mode 0 reads (H-1-r, c).
  - Mode 1 reads (r, W-1-c).
  - Mode 2 reads (r, c).
- CALC is one cycle that computes the result:
  - Mirror: the sampled pixel unchanged.
  - Grayscale: g = (max + min) >> 1 over all NCH channels, using a CW+1-bit sum with the fraction truncated; placement per GRAY_REP.
  - Sharpen interior: per channel, s = 9*center - sum of 8 neighbours in a signed CW+5-bit accumulator; clamp s<0 to 0 and s>2^CW-1 to 2^CW-1.
  - Sharpen border: copy of the sampled pixel.
- WRITE: out_we=1 for exactly this cycle with out_row=r, out_col=c and out_pix=result. Counters then advance raster order (c fastest, wrap c=W-1 to 0 and increment r). After pixel (H-1,W-1) go to DONE, otherwise go to ADDR.
- DONE: done=1 for one cycle; busy drops in the next cycle and the FSM returns to IDLE. A start asserted in the DONE cycle is ignored.
- Cycle accounting (accept edge = cycle 0):
  - Per pixel: one-tap pixel = 4 cycles; sharpen interior pixel = 20 cycles.
  - Modes 0-2: last out_we at cycle 4*W*H, done at 4*W*H+1.
  - Mode 3: total = 20*(W-2)(H-2) + 4*(W*H-(W-2)(H-2)) before done.
- out_we is 0 in every state other than WRITE. out_pix, out_row and out_col hold their last value when out_we=0.

Test Plan:
- Mode 0, 64x64, in[r][c]={r,c} encoded in pixel -> out[r][c]={63-r,c} for all pixels; exactly 4096 out_we pulses; done at cycle 16385; busy high cycles 0..16385.
- Mode 2, pixel 0xC83264 (R200 G50 B100), GRAY_REP=0 -> 0x007D00; with GRAY_REP=1 -> 0x7D7D7D.
- Mode 3, interior center 100 with all neighbours 90 -> 180 per channel. Center 255 with neighbours 0 -> 255 (clamp high). Center 0 with neighbours 255 -> 0 (clamp low). Border pixel copied unchanged. done at cycle 77889 for 64x64.
- Mode 1, IMG_W=5, IMG_H=3, AW=3, NCH=1, CW=4 -> out[r][c]=in[r][4-c]. Check col wrap at c=4 and done at cycle 61.
- Assert rst mid-command in mode 3 -> out_we, busy, done, row and col go to 0 at once with no further writes. A new start afterwards completes normally.
- Pulse start during busy and in the DONE cycle -> ignored. A back-to-back start the cycle after busy falls -> accepted.
